// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_MAX_DATA_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IF   = 2'd1,
        REQ_D    = 2'd2
    } req_t;
endpackage

// File: rtl/mem_arb_select.sv
// Picks which requester gets the memory this cycle and tracks how long fetch
// has been waiting behind back-to-back data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic   i_clk,
    input  logic   i_reset,
    input  state_t i_state,
    input  logic   i_if_req,
    input  logic   i_d_req,
    output req_t   o_grant
);
    localparam int CW = $clog2(MAX_DATA_STREAK + 1);

    // Remaining data grants allowed while fetch waits; zero means streak is full.
    logic [CW-1:0] r_credit;
    logic          w_credit_empty;
    req_t          w_grant;

    assign w_credit_empty = (r_credit == '0);

    always_comb begin
        w_grant = REQ_NONE;
        case (i_state)
            IDLE: begin
                if (i_if_req && i_d_req) w_grant = w_credit_empty ? REQ_IF : REQ_D;
                else if (i_d_req)        w_grant = REQ_D;
                else if (i_if_req)       w_grant = REQ_IF;
            end
            RESP_IF: if (i_d_req)  w_grant = REQ_D;
            RESP_D:  if (i_if_req) w_grant = REQ_IF;
            default: w_grant = REQ_NONE;
        endcase
    end

    assign o_grant = i_reset ? w_grant : REQ_NONE;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_credit <= CW'(MAX_DATA_STREAK);
        end else if (o_grant == REQ_IF || !i_if_req) begin
            r_credit <= CW'(MAX_DATA_STREAK);
        end else if (o_grant == REQ_D && !w_credit_empty) begin
            r_credit <= r_credit - CW'(1);
        end
    end
endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one single-ported synchronous-read memory between fetch and data
// ports, one access at a time with a fixed one-cycle response.
//
// state   | meaning
// IDLE    | nothing in flight
// RESP_IF | fetch issued last cycle; if_ready pulses now
// RESP_D  | data issued last cycle; d_ready pulses now
module unified_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_if_req,
    input  logic [ADDR_WIDTH-1:0]     i_if_adr,
    output logic                      o_if_ready,
    output logic [DATA_WIDTH-1:0]     o_if_rdata,
    input  logic                      i_d_req,
    input  logic                      i_d_we,
    input  logic [ADDR_WIDTH-1:0]     i_d_adr,
    input  logic [DATA_WIDTH-1:0]     i_d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_d_wstrb,
    output logic                      o_d_ready,
    output logic [DATA_WIDTH-1:0]     o_d_rdata,
    output logic                      o_mem_en,
    output logic                      o_mem_we,
    output logic [ADDR_WIDTH-1:0]     o_mem_adr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);
    state_t r_state;
    req_t   w_grant;

    mem_arb_select #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_select (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_state  (r_state),
        .i_if_req (i_if_req),
        .i_d_req  (i_d_req),
        .o_grant  (w_grant)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            case (w_grant)
                REQ_IF:  r_state <= RESP_IF;
                REQ_D:   r_state <= RESP_D;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Issue is combinational so a response cycle can also start the next access.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_adr   = '0;
        o_mem_wdata = '0;
        o_mem_wstrb = '0;
        case (w_grant)
            REQ_IF: begin
                o_mem_en  = 1'b1;
                o_mem_adr = i_if_adr;
            end
            REQ_D: begin
                o_mem_en    = 1'b1;
                o_mem_we    = i_d_we;
                o_mem_adr   = i_d_adr;
                o_mem_wdata = i_d_wdata;
                o_mem_wstrb = i_d_we ? i_d_wstrb : '0;
            end
            default: o_mem_en = 1'b0;
        endcase
    end

    assign o_if_ready = i_reset && (r_state == RESP_IF);
    assign o_d_ready  = i_reset && (r_state == RESP_D);
    assign o_if_rdata = o_if_ready ? i_mem_rdata : '0;
    assign o_d_rdata  = o_d_ready  ? i_mem_rdata : '0;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Scoreboard bench for unified_memory_arbiter: directed scenarios plus two
// randomized requesters against a rule-level reference model.
module tb_unified_memory_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int MAXS   = 4;
    localparam int P_NONE = 0;
    localparam int P_IF   = 1;
    localparam int P_D    = 2;
    localparam int P_BAD  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_adr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_adr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    unified_memory_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_if_req    (if_req),
        .i_if_adr    (if_adr),
        .o_if_ready  (if_ready),
        .o_if_rdata  (if_rdata),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_adr     (d_adr),
        .i_d_wdata   (d_wdata),
        .i_d_wstrb   (d_wstrb),
        .o_d_ready   (d_ready),
        .o_d_rdata   (d_rdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_adr   (mem_adr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wstrb (mem_wstrb),
        .i_mem_rdata (mem_rdata)
    );

    typedef struct {
        bit          st;
        logic [31:0] val;
    } dexp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] env_mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        env_init;
    logic [31:0] if_q [$];
    dexp_t       d_q [$];
    int          prev_issue = P_NONE;
    int          streak     = 0;
    int          exp_issue;
    int          act_issue;
    bit          cand_if;
    bit          cand_d;
    dexp_t       de;
    logic [31:0] ex;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0050_0093;
        return 32'hA5A5_0000 ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory environment: synchronous read, byte-strobed write at issue.
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            mem_rdata <= env_mem[mem_adr[9:2]];
            if (mem_we)
                env_mem[mem_adr[9:2]] <= merge(env_mem[mem_adr[9:2]], mem_wdata, mem_wstrb);
        end
    end

    // Monitor: responses against the scoreboard, issues against the arbitration rules.
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs", 32'(mem_en | mem_we | (|mem_adr) | (|mem_wdata) | (|mem_wstrb)
                | if_ready | d_ready | (|if_rdata) | (|d_rdata)), 32'h0);
            if_q.delete();
            d_q.delete();
            prev_issue = P_NONE;
            streak     = 0;
        end else begin
            chk("if_ready_after_issue", 32'(if_ready), 32'(prev_issue == P_IF));
            chk("d_ready_after_issue", 32'(d_ready), 32'(prev_issue == P_D));
            if (if_ready) begin
                chk("if_ready_expected", 32'(if_q.size() != 0), 32'h1);
                if (if_q.size() != 0) begin
                    ex = if_q.pop_front();
                    chk("if_rdata", if_rdata, ex);
                end
            end else begin
                chk("if_rdata_gated", if_rdata, 32'h0);
            end
            if (d_ready) begin
                chk("d_ready_expected", 32'(d_q.size() != 0), 32'h1);
                if (d_q.size() != 0) begin
                    de = d_q.pop_front();
                    if (!de.st) chk("d_rdata", d_rdata, de.val);
                end
            end else begin
                chk("d_rdata_gated", d_rdata, 32'h0);
            end

            cand_if = if_req && (prev_issue != P_IF);
            cand_d  = d_req && (prev_issue != P_D);
            if (cand_if && cand_d)  exp_issue = (streak >= MAXS) ? P_IF : P_D;
            else if (cand_d)        exp_issue = P_D;
            else if (cand_if)       exp_issue = P_IF;
            else                    exp_issue = P_NONE;

            if (!mem_en)                            act_issue = P_NONE;
            else if (d_req && mem_adr == d_adr)     act_issue = P_D;
            else if (if_req && mem_adr == if_adr)   act_issue = P_IF;
            else                                    act_issue = P_BAD;
            chk("issue_port", 32'(act_issue), 32'(exp_issue));

            if (act_issue == P_D) begin
                chk("d_mem_we", 32'(mem_we), 32'(d_we));
                chk("d_mem_wstrb", 32'(mem_wstrb), d_we ? 32'(d_wstrb) : 32'h0);
                if (d_we) chk("d_mem_wdata", mem_wdata, d_wdata);
            end else if (act_issue == P_IF) begin
                chk("if_mem_we_wstrb", 32'({mem_we, mem_wstrb}), 32'h0);
            end

            if (exp_issue == P_IF || !if_req) streak = 0;
            else if (exp_issue == P_D && streak < MAXS) streak++;
            prev_issue = (act_issue == P_BAD) ? P_NONE : act_issue;
        end
    end

    task automatic wait_ready(input bit is_if);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = is_if ? if_ready : d_ready;
        end
        chk(is_if ? "if_ready_timeout" : "d_ready_timeout", 32'(got), 32'h1);
    endtask

    task automatic do_fetch(input logic [31:0] adr);
        if_adr = adr;
        if_req = 1'b1;
        if_q.push_back(ref_mem[adr[9:2]]);
        wait_ready(1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] strb);
        dexp_t e;
        d_we    = we;
        d_adr   = adr;
        d_wdata = wd;
        d_wstrb = strb;
        d_req   = 1'b1;
        if (we) begin
            ref_mem[adr[9:2]] = merge(ref_mem[adr[9:2]], wd, strb);
            e.st = 1'b1; e.val = 32'h0;
        end else begin
            e.st = 1'b0; e.val = ref_mem[adr[9:2]];
        end
        d_q.push_back(e);
        wait_ready(1'b0);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic gap(input int g);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; env_init = 1'b1;
        if_req = 1'b0; if_adr = '0;
        d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0; d_wstrb = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk); #1;
        env_init = 1'b0;
        rst = 1'b1;

        do_fetch(32'h10);
        do_data(1'b1, 32'hC, 32'h0000_000F, 4'hF);
        do_data(1'b0, 32'hC, 32'h0, 4'h0);

        fork
            do_fetch(32'h20);
            do_data(1'b0, 32'h30, 32'h0, 4'hF);
        join

        fork
            repeat (4) do_fetch(32'h44);
            repeat (8) do_data(1'b0, 32'h204, 32'h0, 4'h0);
        join

        if_adr = 32'h40; if_req = 1'b1;
        if_q.push_back(ref_mem[16]);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        if_q.push_back(ref_mem[16]);
        wait_ready(1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;

        repeat (10) @(posedge clk); #1;

        fork
            for (int n = 0; n < 150; n++) begin
                do_fetch(32'($urandom_range(0, 127)) << 2);
                gap($urandom_range(0, 3));
            end
            for (int n = 0; n < 150; n++) begin
                do_data(1'($urandom_range(0, 1)), 32'h200 | (32'($urandom_range(0, 127)) << 2),
                        $urandom, 4'($urandom_range(0, 15)));
                gap($urandom_range(0, 3));
            end
        join

        repeat (5) @(posedge clk); #1;
        chk("if_q_drained", 32'(if_q.size()), 32'h0);
        chk("d_q_drained", 32'(d_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
